// File: rtl/reg_desp_rx_pkg.sv
// Shared definitions for the serial-to-parallel receive stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: default word width, FIFO occupancy encoding, serial direction constants.
package reg_desp_rx_pkg;

    localparam int WIDTH_DEF = 4;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } fifo_st_e;

    localparam logic DIR_MSB_FIRST = 1'b0;
    localparam logic DIR_LSB_FIRST = 1'b1;

endpackage

// File: rtl/reg_desp_rx_if.sv
// Bundle of the receive stage's serial input, control and word-output signals.
// Latency: n/a (wiring only).
// Backpressure: ready from the consumer; valid/data_out are driven by the receiver.
//
// Modports: master = stimulus/consumer side, slave = reg_desp_rx side.
interface reg_desp_rx_if #(
    parameter int WIDTH = 4
) ();
    localparam int CNT_W = $clog2(WIDTH);

    logic             enb;
    logic             dir;
    logic             s_in;
    logic             clr;
    logic             ready;
    logic [WIDTH-1:0] data_out;
    logic             valid;
    logic [CNT_W-1:0] bit_cnt;
    logic             overflow;

    modport master (
        output enb, dir, s_in, clr, ready,
        input  data_out, valid, bit_cnt, overflow
    );

    modport slave (
        input  enb, dir, s_in, clr, ready,
        output data_out, valid, bit_cnt, overflow
    );
endinterface

// File: rtl/reg_desp_rx_fifo2.sv
// Two-entry word FIFO with an EMPTY/ONE/FULL occupancy FSM; drops pushes that find it full.
// Latency: a pushed word is visible on head_dat_o the cycle after the push edge.
// Backpressure: pop_i is honoured only while head_vld_o=1; a push into FULL without pop is dropped (drop_o).
//
// Ports: clk, reset_L (async active-low), clr_i (sync clear, overrides push/pop),
//        push_i/push_dat_i, pop_i, head_dat_o/head_vld_o (registered), drop_o (comb).
module reg_desp_rx_fifo2
    import reg_desp_rx_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_dat_o,
    output logic             head_vld_o,
    output logic             drop_o
);

    fifo_st_e         state_q, state_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic             push, pop;

    // clr wins over both sides; a pop needs something to pop.
    assign push = push_i & ~clr_i;
    assign pop  = pop_i & ~clr_i & (state_q != ST_EMPTY);

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q <= ST_EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        drop_o  = 1'b0;
        if (clr_i) begin
            state_d = ST_EMPTY;
            head_d  = '0;
            tail_d  = '0;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (push) begin
                        head_d  = push_dat_i;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (push && pop) begin
                        head_d = push_dat_i;
                    end else if (push) begin
                        tail_d  = push_dat_i;
                        state_d = ST_FULL;
                    end else if (pop) begin
                        // Zero the head so data_out reads 0 whenever nothing is buffered.
                        head_d  = '0;
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (pop) begin
                        head_d = tail_q;
                        if (push) begin
                            tail_d = push_dat_i;
                        end else begin
                            tail_d  = '0;
                            state_d = ST_ONE;
                        end
                    end else if (push) begin
                        // Never overwrite a buffered word: the new one is lost instead.
                        drop_o = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    head_d  = '0;
                    tail_d  = '0;
                end
            endcase
        end
    end

    assign head_dat_o = head_q;
    assign head_vld_o = (state_q != ST_EMPTY);

endmodule

// File: rtl/reg_desp_rx.sv
// Serial-to-parallel capture: shifts s_in on enb strobes into WIDTH-bit words and queues them.
// Latency: valid rises the cycle after the edge that samples a word's last bit.
// Backpressure: valid/ready with a 2-word buffer; words completing into a full buffer are dropped and flag sticky overflow.
//
// Ports: clk, reset_L (async active-low), bus (slave modport): enb, dir, s_in, clr, ready in;
//        data_out, valid, bit_cnt, overflow out (all registered or decoded from registers).
module reg_desp_rx
    import reg_desp_rx_pkg::*;
#(
    parameter  int WIDTH = WIDTH_DEF,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic         clk,
    input  logic         reset_L,
    reg_desp_rx_if.slave bus
);

    logic [WIDTH-1:0] sr_q, sr_d, sr_n;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic             ovf_q, ovf_d;
    logic             eff_dir;
    logic             last_bit;
    logic             push;
    logic             drop;
    logic             fifo_vld;
    logic [WIDTH-1:0] fifo_dat;

    // The first bit of a word picks the direction live; the rest of the word
    // follows the latched copy so mid-word dir changes have no effect.
    assign eff_dir  = (cnt_q == '0) ? bus.dir : dir_q;
    assign sr_n     = (eff_dir == DIR_MSB_FIRST) ? {sr_q[WIDTH-2:0], bus.s_in}
                                                 : {bus.s_in, sr_q[WIDTH-1:1]};
    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));
    assign push     = bus.enb & ~bus.clr & last_bit;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            sr_q  <= '0;
            cnt_q <= '0;
            dir_q <= DIR_MSB_FIRST;
            ovf_q <= 1'b0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
            dir_q <= dir_d;
            ovf_q <= ovf_d;
        end
    end

    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        dir_d = dir_q;
        ovf_d = ovf_q | drop;
        if (bus.clr) begin
            sr_d  = '0;
            cnt_d = '0;
            dir_d = DIR_MSB_FIRST;
            ovf_d = 1'b0;
        end else if (bus.enb) begin
            if (cnt_q == '0) begin
                dir_d = bus.dir;
            end
            if (last_bit) begin
                // The completed word leaves through the FIFO push; start clean.
                sr_d  = '0;
                cnt_d = '0;
            end else begin
                sr_d  = sr_n;
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    reg_desp_rx_fifo2 #(
        .WIDTH (WIDTH)
    ) u_fifo (
        .clk        (clk),
        .reset_L    (reset_L),
        .clr_i      (bus.clr),
        .push_i     (push),
        .push_dat_i (sr_n),
        .pop_i      (bus.ready),
        .head_dat_o (fifo_dat),
        .head_vld_o (fifo_vld),
        .drop_o     (drop)
    );

    assign bus.data_out = fifo_dat;
    assign bus.valid    = fifo_vld;
    assign bus.bit_cnt  = cnt_q;
    assign bus.overflow = ovf_q;

endmodule
